// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit registers with per-stage valid bits,
// bubble collapse, flush and a registered occupancy count.
module pipe_reg_chain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [OccW-1:0]  r_occ;

  logic [DEPTH-1:0] w_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // A stage advances when it holds a word and the next stage is empty or itself advancing.
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = r_valid[DEPTH-1] & out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      w_adv[i] = r_valid[i] & (~r_valid[i+1] | w_adv[i+1]);
    end
  end

  assign in_ready   = (~r_valid[0] | w_adv[0]) & ~flush & ~reset;
  assign out_valid  = r_valid[DEPTH-1] & ~flush;
  assign out_data   = r_data[DEPTH-1];
  assign occupancy  = r_occ;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
      end
    end else if (flush) begin
      // Data registers are left as they are; only validity matters.
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      if (w_in_xfer) begin
        r_valid[0] <= 1'b1;
        r_data[0]  <= in_data;
      end else if (w_adv[0]) begin
        r_valid[0] <= 1'b0;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (w_adv[i-1]) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= r_data[i-1];
        end else if (w_adv[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      r_occ <= r_occ + OccW'(w_in_xfer) - OccW'(w_out_xfer);
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed table-driven bench for pipe_reg_chain (WIDTH=8, DEPTH=4).
module tb_pipe_reg_chain;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  int n_vec;
  int n_err;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       chk;
    logic       e_ird;
    logic       e_ov;
    logic [7:0] e_od;
    logic       od_chk;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tbl[$];

  pipe_reg_chain #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [7:0] id,
                     input logic ordy, input logic chk, input logic e_ird, input logic e_ov,
                     input logic [7:0] e_od, input logic od_chk, input logic [2:0] e_occ);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy; v.chk = chk;
    v.e_ird = e_ird; v.e_ov = e_ov; v.e_od = e_od; v.od_chk = od_chk; v.e_occ = e_occ;
    tbl.push_back(v);
  endtask

  // Drive inputs, check pre-edge outputs on the falling edge, then let the rising edge happen.
  task automatic apply(input vec_t v, input int idx, input string tag);
    reset     = v.rst;
    flush     = v.fl;
    in_valid  = v.iv;
    in_data   = v.id;
    out_ready = v.ordy;
    @(negedge clk);
    if (v.chk) begin
      n_vec++;
      if (in_ready !== v.e_ird) begin
        n_err++;
        $display("FAIL %s[%0d] in_ready: got %b want %b", tag, idx, in_ready, v.e_ird);
      end
      if (out_valid !== v.e_ov) begin
        n_err++;
        $display("FAIL %s[%0d] out_valid: got %b want %b", tag, idx, out_valid, v.e_ov);
      end
      if (v.od_chk && out_data !== v.e_od) begin
        n_err++;
        $display("FAIL %s[%0d] out_data: got %h want %h", tag, idx, out_data, v.e_od);
      end
      if (occupancy !== v.e_occ) begin
        n_err++;
        $display("FAIL %s[%0d] occupancy: got %0d want %0d", tag, idx, occupancy, v.e_occ);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;

    //  rst fl iv  id     ordy chk ird ov  od    odc occ
    // reset for two cycles, then single word latency with out_ready=1
    add(1, 0, 0, 8'h00, 0,   0,  0,  0,  8'h00, 0,  0);
    add(1, 0, 0, 8'h00, 0,   1,  0,  0,  8'h00, 1,  0);
    add(0, 0, 1, 8'hA5, 1,   1,  1,  0,  8'h00, 1,  0);
    add(0, 0, 0, 8'h00, 1,   1,  1,  0,  8'h00, 0,  1);
    add(0, 0, 0, 8'h00, 1,   1,  1,  0,  8'h00, 0,  1);
    add(0, 0, 0, 8'h00, 1,   1,  1,  0,  8'h00, 0,  1);
    add(0, 0, 0, 8'h00, 1,   1,  1,  1,  8'hA5, 1,  1);
    // back-pressure fill 01..05, then drain
    add(0, 0, 1, 8'h01, 0,   1,  1,  0,  8'h00, 0,  0);
    add(0, 0, 1, 8'h02, 0,   1,  1,  0,  8'h00, 0,  1);
    add(0, 0, 1, 8'h03, 0,   1,  1,  0,  8'h00, 0,  2);
    add(0, 0, 1, 8'h04, 0,   1,  1,  0,  8'h00, 0,  3);
    add(0, 0, 1, 8'h05, 0,   1,  0,  1,  8'h01, 1,  4);
    add(0, 0, 1, 8'h05, 0,   1,  0,  1,  8'h01, 1,  4);
    add(0, 0, 1, 8'h05, 1,   1,  1,  1,  8'h01, 1,  4);
    add(0, 0, 0, 8'h00, 1,   1,  1,  1,  8'h02, 1,  4);
    add(0, 0, 0, 8'h00, 1,   1,  1,  1,  8'h03, 1,  3);
    add(0, 0, 0, 8'h00, 1,   1,  1,  1,  8'h04, 1,  2);
    add(0, 0, 0, 8'h00, 1,   1,  1,  1,  8'h05, 1,  1);
    add(0, 0, 0, 8'h00, 0,   1,  1,  0,  8'h00, 0,  0);
    // bubble collapse: 11, two idle cycles, 22, out_ready=0
    add(0, 0, 1, 8'h11, 0,   1,  1,  0,  8'h00, 0,  0);
    add(0, 0, 0, 8'h00, 0,   1,  1,  0,  8'h00, 0,  1);
    add(0, 0, 0, 8'h00, 0,   1,  1,  0,  8'h00, 0,  1);
    add(0, 0, 1, 8'h22, 0,   1,  1,  0,  8'h00, 0,  1);
    add(0, 0, 0, 8'h00, 0,   1,  1,  1,  8'h11, 1,  2);
    add(0, 0, 0, 8'h00, 0,   1,  1,  1,  8'h11, 1,  2);
    add(0, 0, 0, 8'h00, 0,   1,  1,  1,  8'h11, 1,  2);
    add(0, 0, 0, 8'h00, 0,   1,  1,  1,  8'h11, 1,  2);
    // top up to full, then flush with in_valid and out_ready high
    add(0, 0, 1, 8'h33, 0,   1,  1,  1,  8'h11, 1,  2);
    add(0, 0, 1, 8'h44, 0,   1,  1,  1,  8'h11, 1,  3);
    add(0, 0, 1, 8'h55, 0,   1,  0,  1,  8'h11, 1,  4);
    add(0, 1, 1, 8'h55, 1,   1,  0,  0,  8'h00, 0,  4);
    add(0, 0, 0, 8'h00, 0,   1,  1,  0,  8'h00, 0,  0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i, "tbl");
    end

    // reset in the middle of a stream, then watch for stale words
    v = '{0, 0, 1, 8'h61, 1, 1, 1, 0, 8'h00, 0, 0};
    apply(v, 0, "rst_mid");
    v = '{0, 0, 1, 8'h62, 1, 1, 1, 0, 8'h00, 0, 1};
    apply(v, 1, "rst_mid");
    v = '{0, 0, 1, 8'h63, 1, 1, 1, 0, 8'h00, 0, 2};
    apply(v, 2, "rst_mid");
    v = '{1, 0, 1, 8'h64, 1, 1, 0, 0, 8'h00, 0, 3};
    apply(v, 3, "rst_mid");
    for (int i = 0; i < 8; i++) begin
      v = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 1, 0};
      apply(v, 4 + i, "rst_after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
